// File: rtl/axi_buffer_rab_bram_lvl.sv
// First-word fall-through FIFO on a synchronous-read RAM with one output register,
// exact fill level, programmable almost-full/almost-empty flags and a synchronous flush.
module axi_buffer_rab_bram_lvl #(
  parameter int DATA_WIDTH       = 32,
  parameter int BUFFER_DEPTH     = 512,
  parameter int LOG_BUFFER_DEPTH = 9
) (
  input  logic                        clk,
  input  logic                        rstn,
  output logic [DATA_WIDTH-1:0]       data_out,
  output logic                        valid_out,
  input  logic                        ready_in,
  input  logic                        valid_in,
  input  logic [DATA_WIDTH-1:0]       data_in,
  output logic                        ready_out,
  input  logic                        flush_entries,
  input  logic [LOG_BUFFER_DEPTH:0]   af_thresh,
  input  logic [LOG_BUFFER_DEPTH:0]   ae_thresh,
  output logic [LOG_BUFFER_DEPTH:0]   level,
  output logic                        almost_full,
  output logic                        almost_empty
);

  localparam int LW = LOG_BUFFER_DEPTH + 1;
  localparam logic [LW-1:0]               DEPTH_L  = LW'(BUFFER_DEPTH);
  localparam logic [LW-1:0]               ONE_L    = LW'(1);
  localparam logic [LOG_BUFFER_DEPTH-1:0] LAST_PTR = LOG_BUFFER_DEPTH'(BUFFER_DEPTH - 1);
  localparam logic [LOG_BUFFER_DEPTH-1:0] PTR_ONE  = LOG_BUFFER_DEPTH'(1);

  logic [DATA_WIDTH-1:0]       mem [BUFFER_DEPTH];
  logic [LOG_BUFFER_DEPTH-1:0] wr_ptr;
  logic [LOG_BUFFER_DEPTH-1:0] rd_ptr;
  logic [LW-1:0]               ram_cnt;
  logic [LW-1:0]               level_q;
  logic [DATA_WIDTH-1:0]       rdata;
  logic                        rdata_valid;
  logic                        out_valid;
  logic [DATA_WIDTH-1:0]       out_data;

  logic push;
  logic pop;
  logic load_out;
  logic rd_issue;

  // Pointers wrap at BUFFER_DEPTH-1, so non power-of-two depths work.
  function automatic logic [LOG_BUFFER_DEPTH-1:0] next_ptr(input logic [LOG_BUFFER_DEPTH-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_ONE;
  endfunction

  // ram_cnt only counts entries written at earlier edges, so a read never hits
  // the address being written in the same cycle.
  always_comb begin
    ready_out = rstn && !flush_entries && (level_q < DEPTH_L);
    push      = valid_in && ready_out;
    pop       = out_valid && ready_in;
    load_out  = rdata_valid && (!out_valid || pop);
    rd_issue  = (ram_cnt != '0) && (!rdata_valid || load_out) && !flush_entries;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
    if (rd_issue) rdata <= mem[rd_ptr];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      ram_cnt     <= '0;
      level_q     <= '0;
      rdata_valid <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
    end else if (flush_entries) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      ram_cnt     <= '0;
      level_q     <= '0;
      rdata_valid <= 1'b0;
      out_valid   <= 1'b0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (rd_issue) rd_ptr <= next_ptr(rd_ptr);
      if (push && !rd_issue) ram_cnt <= ram_cnt + ONE_L;
      else if (!push && rd_issue) ram_cnt <= ram_cnt - ONE_L;
      if (rd_issue) rdata_valid <= 1'b1;
      else if (load_out) rdata_valid <= 1'b0;
      if (load_out) begin
        out_valid <= 1'b1;
        out_data  <= rdata;
      end else if (pop) begin
        out_valid <= 1'b0;
      end
      if (push && !pop) level_q <= level_q + ONE_L;
      else if (pop && !push) level_q <= level_q - ONE_L;
    end
  end

  always_comb begin
    data_out     = out_data;
    valid_out    = out_valid;
    level        = level_q;
    almost_full  = (level_q >= af_thresh);
    almost_empty = (level_q <= ae_thresh);
  end

endmodule

// File: tb/tb_axi_buffer_rab_bram_lvl.sv
// Bench for axi_buffer_rab_bram_lvl: directed and randomized traffic checked against
// a queue model of the FIFO contents.
module tb_axi_buffer_rab_bram_lvl;

  localparam int DW    = 8;
  localparam int DEPTH = 5;
  localparam int LOG   = 3;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          ready_in;
  logic          valid_in;
  logic [DW-1:0] data_in;
  logic          ready_out;
  logic          flush_entries;
  logic [LOG:0]  af_thresh;
  logic [LOG:0]  ae_thresh;
  logic [LOG:0]  level;
  logic          almost_full;
  logic          almost_empty;

  logic [DW-1:0] q[$];
  int            checks = 0;
  int            errors = 0;
  int            popped = 0;
  logic          pushed_flag;

  axi_buffer_rab_bram_lvl #(
    .DATA_WIDTH(DW), .BUFFER_DEPTH(DEPTH), .LOG_BUFFER_DEPTH(LOG)
  ) dut (
    .clk(clk), .rstn(rstn), .data_out(data_out), .valid_out(valid_out),
    .ready_in(ready_in), .valid_in(valid_in), .data_in(data_in),
    .ready_out(ready_out), .flush_entries(flush_entries),
    .af_thresh(af_thresh), .ae_thresh(ae_thresh), .level(level),
    .almost_full(almost_full), .almost_empty(almost_empty)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Level, handshake and flags follow directly from the number of entries held.
  task automatic checkOutput(input logic fl);
    checkVal("level", 32'(level), 32'(q.size()));
    checkVal("ready_out", 32'(ready_out), 32'((q.size() < DEPTH) && !fl));
    checkVal("almost_full", 32'(almost_full), 32'(q.size() >= int'(af_thresh)));
    checkVal("almost_empty", 32'(almost_empty), 32'(q.size() <= int'(ae_thresh)));
    if (q.size() == 0) checkVal("valid_when_empty", 32'(valid_out), 32'd0);
  endtask

  task automatic checkReset(input string tag);
    checkVal({tag, "_valid"}, 32'(valid_out), 32'd0);
    checkVal({tag, "_ready"}, 32'(ready_out), 32'd0);
    checkVal({tag, "_level"}, 32'(level), 32'd0);
    checkVal({tag, "_ae"}, 32'(almost_empty), 32'd1);
    checkVal({tag, "_af"}, 32'(almost_full), 32'(af_thresh == 0));
    checkVal({tag, "_data"}, 32'(data_out), 32'd0);
  endtask

  task automatic applyStimulus(input logic vi, input logic [DW-1:0] di, input logic ri,
                               input logic fl, output logic pushed);
    @(negedge clk);
    valid_in = vi;
    data_in = di;
    ready_in = ri;
    flush_entries = fl;
    #1;
    checkOutput(fl);
    pushed = valid_in && ready_out;
    if (valid_out && ready_in && q.size() != 0) begin
      checkVal("pop_data", 32'(data_out), 32'(q[0]));
      popped++;
      void'(q.pop_front());
    end
    if (fl) q.delete();
    else if (pushed) q.push_back(di);
  endtask

  task automatic drain(input string tag);
    logic p;
    for (int n = 0; n < 60 && q.size() != 0; n++) applyStimulus(1'b0, '0, 1'b1, 1'b0, p);
    checkVal(tag, 32'(q.size()), 32'd0);
  endtask

  initial begin
    int base;
    int sent;
    int v;
    logic pend;

    valid_in = 1'b0; data_in = '0; ready_in = 1'b0; flush_entries = 1'b0;
    af_thresh = 4'd4; ae_thresh = 4'd1;

    repeat (2) @(negedge clk);
    #1 checkReset("rst");
    af_thresh = 4'd0;
    #1 checkVal("rst_af_zero", 32'(almost_full), 32'd1);
    af_thresh = 4'd4;
    @(negedge clk);
    #2 rstn = 1'b1;

    // Fill to capacity with the consumer stalled, then a stalled sixth word.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, DW'(8'h11 + i), 1'b0, 1'b0, pushed_flag);
    applyStimulus(1'b1, 8'h16, 1'b0, 1'b0, pushed_flag);
    checkVal("stall_sixth", 32'(pushed_flag), 32'd0);
    checkVal("full_level", 32'(level), 32'd5);
    base = popped;
    pend = 1'b1;
    for (int n = 0; n < 40 && (pend || q.size() != 0); n++) begin
      applyStimulus(pend, 8'h16, 1'b1, 1'b0, pushed_flag);
      if (pushed_flag) pend = 1'b0;
    end
    checkVal("drain_done", 32'(q.size() == 0 && !pend), 32'd1);
    checkVal("drain_count", 32'(popped - base), 32'd6);

    // Empty-FIFO latency and output stability under backpressure.
    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0, pushed_flag);
    checkVal("lat_push", 32'(pushed_flag), 32'd1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, pushed_flag);
    checkVal("lat_k0", 32'(valid_out), 32'd0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, pushed_flag);
    checkVal("lat_k1", 32'(valid_out), 32'd0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, pushed_flag);
    checkVal("lat_k2", 32'(valid_out), 32'd1);
    checkVal("lat_data", 32'(data_out), 32'hA5);
    repeat (10) begin
      applyStimulus(1'b0, '0, 1'b0, 1'b0, pushed_flag);
      checkVal("hold_valid", 32'(valid_out), 32'd1);
      checkVal("hold_data", 32'(data_out), 32'hA5);
    end
    drain("lat_drain");

    // Randomized streaming through several pointer wraps.
    base = popped;
    sent = 0;
    for (int n = 0; n < 2000 && (sent < 40 || q.size() != 0); n++) begin
      applyStimulus(sent < 40 && ($urandom % 2 == 0), DW'(sent), ($urandom % 4 != 0),
                    1'b0, pushed_flag);
      if (pushed_flag) sent++;
    end
    checkVal("stream_sent", 32'(sent), 32'd40);
    checkVal("stream_popped", 32'(popped - base), 32'd40);

    // Steady state at level 3: one push and one pop every cycle.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, DW'(100 + i), 1'b0, 1'b0, pushed_flag);
    repeat (2) applyStimulus(1'b0, '0, 1'b0, 1'b0, pushed_flag);
    v = 103;
    repeat (12) begin
      applyStimulus(1'b1, DW'(v), 1'b1, 1'b0, pushed_flag);
      checkVal("steady_push", 32'(pushed_flag), 32'd1);
      checkVal("steady_valid", 32'(valid_out), 32'd1);
      checkVal("steady_level", 32'(level), 32'd3);
      if (pushed_flag) v++;
    end
    drain("steady_drain");

    // Almost-full disabled by a threshold above the depth.
    af_thresh = 4'd6;
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, DW'(8'h60 + i), 1'b0, 1'b0, pushed_flag);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, pushed_flag);
    checkVal("af6_full_level", 32'(level), 32'd5);
    checkVal("af6_flag", 32'(almost_full), 32'd0);
    drain("af6_drain");
    af_thresh = 4'd4;

    // Flush during a pop while a prefetch read is in flight.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, DW'(8'h31 + i), 1'b0, 1'b0, pushed_flag);
    applyStimulus(1'b0, '0, 1'b1, 1'b1, pushed_flag);
    checkVal("flush_pre_valid", 32'(valid_out), 32'd1);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, pushed_flag);
    checkVal("flush_valid", 32'(valid_out), 32'd0);
    checkVal("flush_level", 32'(level), 32'd0);
    repeat (4) applyStimulus(1'b0, '0, 1'b1, 1'b0, pushed_flag);
    applyStimulus(1'b1, 8'h77, 1'b0, 1'b0, pushed_flag);
    for (int n = 0; n < 10 && !valid_out; n++) applyStimulus(1'b0, '0, 1'b0, 1'b0, pushed_flag);
    checkVal("flush_first_valid", 32'(valid_out), 32'd1);
    checkVal("flush_first_data", 32'(data_out), 32'h77);
    drain("flush_drain");

    // Asynchronous reset with entries held; nothing stale may reappear.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, DW'(8'h41 + i), 1'b0, 1'b0, pushed_flag);
    repeat (2) applyStimulus(1'b0, '0, 1'b0, 1'b0, pushed_flag);
    checkVal("async_pre_level", 32'(level), 32'd4);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1 checkReset("async");
    q.delete();
    @(negedge clk);
    #2 rstn = 1'b1;
    repeat (6) applyStimulus(1'b0, '0, 1'b1, 1'b0, pushed_flag);
    applyStimulus(1'b1, 8'h55, 1'b1, 1'b0, pushed_flag);
    for (int n = 0; n < 10 && !valid_out; n++) applyStimulus(1'b0, '0, 1'b1, 1'b0, pushed_flag);
    checkVal("async_after_data", 32'(data_out), 32'h55);
    drain("async_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_buffer_rab_bram_lvl.md
Name: axi_buffer_rab_bram_lvl

Overview:
- Parametrised first-word fall-through (FWFT) FIFO for the RAB AXI channel buffering path, built on a synchronous-read dual-port RAM plus one output register.
- Successor of the basic BRAM buffer: supports any depth (not only 2^n) and has an exact fill-level output.
- Adds runtime-programmable almost-full/almost-empty flags and a flush that is glitch-free against the RAM read latency.
- Sits between an AXI channel producer and the RAB/slave-side consumer wherever deep elastic buffering with backpressure look-ahead is needed.

Parameters:
DATA_WIDTH, 32, payload width in bits (>=1)
BUFFER_DEPTH, 512, total entries accepted before ready_out drops (>=2, any integer)
LOG_BUFFER_DEPTH, 9, pointer width; must equal $clog2(BUFFER_DEPTH)

Ports:
clk  in  1  clock; all logic is rising-edge
rstn  in  1  reset, asynchronous, active-low
data_out  out  DATA_WIDTH  head entry; valid only while valid_out=1
valid_out  out  1  head entry present
ready_in  in  1  downstream accepts head
valid_in  in  1  upstream offers data_in
data_in  in  DATA_WIDTH  payload
ready_out  out  1  FIFO accepts data_in
flush_entries  in  1  synchronous flush, discards all content
af_thresh  in  LOG_BUFFER_DEPTH+1  almost-full threshold
ae_thresh  in  LOG_BUFFER_DEPTH+1  almost-empty threshold
level  out  LOG_BUFFER_DEPTH+1  entries accepted and not yet popped
almost_full  out  1  level >= af_thresh
almost_empty  out  1  level <= ae_thresh

Behaviour:
- Reset is asynchronous and active-low, clock clk. While rstn=0: valid_out=0, ready_out=0, level=0, almost_empty=1, almost_full=(af_thresh==0), data_out=0, pointers=0. ready_out=1 from the first cycle after release.
- Push occurs at an edge where valid_in && ready_out. Pop occurs at an edge where valid_out && ready_in.
- Push while full is impossible because ready_out=0. A valid_in held high is then simply stalled; RAM and pointers stay unchanged. The RAM write enable is exactly push.
- ready_out = (level < BUFFER_DEPTH) && !flush_entries.
- valid_out is registered. data_out is driven from the output register and holds stable while valid_out && !ready_in (AXI-stable).
- Latency: when the FIFO is empty, an entry pushed at edge k is presented with valid_out=1 in the cycle after edge k+2.
  - Read-during-write on the same RAM address is never issued; the prefetch read is delayed one cycle after the write.
- In steady state the FIFO gives one push and one pop per cycle, with no bubbles.
- Prefetch: the output register refills from RAM without a bubble. The RAM read address is advanced combinationally on a pop, so the next entry lands in the output register at the same edge the current one leaves.
- Ordering: strict FIFO order, no duplication or loss. This holds across any valid_in/ready_in pattern.
- Wrap-around: write and read pointers run from 0 to BUFFER_DEPTH-1, then return to 0. No modulo-2^n assumption is made.
- level:
  - +1 on push only, -1 on pop only, unchanged on push+pop or on neither.
  - level counts entries in RAM, in the prefetch pipeline and in the output register.
  - level is never above BUFFER_DEPTH and never below 0.
- Simultaneous push and pop at level=BUFFER_DEPTH cannot occur (ready_out=0). At level 0 a pop cannot occur (valid_out=0).
- almost_full and almost_empty are combinational compares of the registered level against the live thresholds.
  - af_thresh > BUFFER_DEPTH means almost_full never asserts.
  - ae_thresh=0 means almost_empty asserts only when empty.
- flush_entries=1 at an edge takes priority over push and pop at that edge.
  - It sets pointers=0, level=0 and valid_out=0.
  - Any in-flight RAM read is invalidated and never reaches valid_out.
  - ready_out=0 during the flush cycle; normal operation resumes the next cycle.
  - Flush of an empty FIFO is a no-op.
- Reset asserted mid-operation clears state immediately, independent of clk. No entry present before reset may appear afterwards.
- RAM contents are not reset. Correctness relies only on pointers and valid state.

Test Plan:
- Fill/drain (BUFFER_DEPTH=5, ready_in=0): push 0x11..0x15 -> ready_out=0 after 5th push, level=5, 6th (0x16) stalled. Then ready_in=1 -> out 0x11..0x15, then 0x16, level back to 0.
- Empty latency: single push 0xA5 at edge k -> valid_out=1, data_out=0xA5 in cycle after k+2. With ready_in=0, data_out holds 0xA5 for 10 cycles.
- Streaming/wrap (BUFFER_DEPTH=5): 40 sequential values, random valid_in and ready_in -> output is exactly 0..39 in order. With both held high at level 3, level stays 3 and there is one transfer per cycle.
- Thresholds (BUFFER_DEPTH=5, af_thresh=4, ae_thresh=1): levels 0,1,2,3,4,5 -> almost_empty 1,1,0,0,0,0 and almost_full 0,0,0,0,1,1. Setting af_thresh=6 -> almost_full stays 0.
- Flush: level=3, a prefetch in flight, flush_entries pulsed during a pop -> next cycle level=0, valid_out=0. Push 0x77 -> first output is 0x77.
- Async reset: rstn pulled low mid-cycle with level=4 -> outputs reach reset values before the next edge. After release, valid_out=0 and no stale data appears.
